// File: rtl/div_unit.sv
// div_unit: iterative 32-step restoring divider for the HI/LO unit.
// It handles signed (DIV) and unsigned (DIVU) division, flags division by
// zero, and can be cancelled by a pipeline flush. Results are held between
// done pulses.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Absolute value of an operand. A signed most-negative value maps to
  // 2^(DATA_W-1), which still fits as an unsigned DATA_W-bit magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    if (is_signed && sv[DATA_W-1]) return -sv;
    return v;
  endfunction

  // Two's-complement negate when requested; wraps for the most-negative value.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    if (neg) return -sv;
    return v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;     // partial remainder magnitude
  logic [DATA_W-1:0] qw_q, qw_d;       // dividend bits shifting out, quotient bits shifting in
  logic [DATA_W-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic              negq_q, negq_d;   // quotient must be negated
  logic              negr_q, negr_d;   // remainder takes a negative sign
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic              dbz_q, dbz_d;

  // One restoring step: shift the next dividend bit into a 33-bit trial
  // remainder and subtract the divisor if it fits. When it fits the
  // difference is below the divisor, so the low DATA_W bits are exact.
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] qw_step;

  assign shifted  = {rem_q, qw_q[DATA_W-1]};
  assign fits     = (shifted >= {1'b0, dvs_q});
  assign diff     = shifted[DATA_W-1:0] - dvs_q;
  assign rem_step = fits ? diff : shifted[DATA_W-1:0];
  assign qw_step  = {qw_q[DATA_W-2:0], fits};

  // Next-state, datapath and result selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    qw_d        = qw_q;
    dvs_d       = dvs_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !cancel) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            qw_d    = magnitude(dividend, signed_div);
            dvs_d   = magnitude(divisor, signed_div);
            negq_d  = signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            negr_d  = signed_div & dividend[DATA_W-1];
          end
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          qw_d  = qw_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d     = DONE;
            quotient_d  = cond_neg(qw_step, negq_q);
            remainder_d = cond_neg(rem_step, negr_q);
            dbz_d       = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and visible results; reset clears them.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Working datapath registers; always loaded before use, so no reset.
  always_ff @(posedge cpu_clk_50M) begin
    rem_q  <= rem_d;
    qw_q   <= qw_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
